// File: rtl/trig_readout_sequencer_if.sv
// Bus between the trigger logic / PCI register bank and the readout sequencer.
// Requests, SCROD ACK inputs, TRG outputs and the statistics counters.
interface trig_readout_sequencer_if #(
  parameter int N_SCROD = 12,
  parameter int EVT_W   = 32
);
  // Handshake: TRG_REQ is a level request with no ready. Each cycle it is high
  // counts as one request. It is accepted at an edge where the sequencer is idle
  // and TRG_MASK != 0; it is dropped (and counted) at any edge where BUSY is high.
  logic               TRG_REQ;
  logic [N_SCROD-1:0] TRG_MASK;
  logic [15:0]        TIMEOUT_CYC;
  logic [7:0]         HOLDOFF_CYC;
  logic [N_SCROD-1:0] ACK;
  logic               EVT_LOAD;
  logic [EVT_W-1:0]   EVT_LOAD_VAL;

  logic [N_SCROD-1:0] TRG;
  logic               BUSY;
  logic [EVT_W-1:0]   EVT_CNT;
  logic [15:0]        TIMEOUT_CNT;
  logic [15:0]        DROP_CNT;
  logic [N_SCROD-1:0] TIMEOUT_MASK;

  modport master (
    output TRG_REQ, TRG_MASK, TIMEOUT_CYC, HOLDOFF_CYC, ACK, EVT_LOAD, EVT_LOAD_VAL,
    input  TRG, BUSY, EVT_CNT, TIMEOUT_CNT, DROP_CNT, TIMEOUT_MASK
  );

  modport slave (
    input  TRG_REQ, TRG_MASK, TIMEOUT_CYC, HOLDOFF_CYC, ACK, EVT_LOAD, EVT_LOAD_VAL,
    output TRG, BUSY, EVT_CNT, TIMEOUT_CNT, DROP_CNT, TIMEOUT_MASK
  );
endinterface

// File: rtl/trig_readout_sequencer.sv
// Sequences one trigger/readout cycle across the SCROD links: TRG pulse,
// ACK collection with timeout, hold-off, plus event/timeout/drop statistics.
module trig_readout_sequencer #(
  parameter int N_SCROD       = 12,
  parameter int TRG_PULSE_CYC = 4,
  parameter int EVT_W         = 32
) (
  input  logic                       CLK_42MHZ,
  input  logic                       RESET,
  trig_readout_sequencer_if.slave    bus,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(TRG_PULSE_CYC - 1);

  state_t             state, state_nxt;
  logic [N_SCROD-1:0] pending, pending_nxt, pending_clr;
  logic [15:0]        timer, timer_nxt;
  logic [N_SCROD-1:0] trg_q, trg_nxt;
  logic [N_SCROD-1:0] tmask_q, tmask_nxt;
  logic [EVT_W-1:0]   evt_q;
  logic [15:0]        tcnt_q, dcnt_q;
  logic               busy_q;
  logic               evt_inc, tmo_inc, drop_inc;
  logic [15:0]        hold_last;

  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      pending <= '0;
      timer   <= '0;
      trg_q   <= '0;
      tmask_q <= '0;
      evt_q   <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      timer   <= timer_nxt;
      trg_q   <= trg_nxt;
      tmask_q <= tmask_nxt;
      busy_q  <= (state_nxt != IDLE);
      if (bus.EVT_LOAD)
        evt_q <= bus.EVT_LOAD_VAL;
      else if (evt_inc)
        evt_q <= evt_q + EVT_W'(1);
      if (tmo_inc && tcnt_q != 16'hFFFF)
        tcnt_q <= tcnt_q + 16'd1;
      if (drop_inc && dcnt_q != 16'hFFFF)
        dcnt_q <= dcnt_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    timer_nxt   = timer;
    trg_nxt     = trg_q;
    tmask_nxt   = tmask_q;
    evt_inc     = 1'b0;
    tmo_inc     = 1'b0;
    drop_inc    = 1'b0;
    pending_clr = pending & ~bus.ACK;
    // A hold-off of 0 still spends one cycle in HOLDOFF.
    hold_last   = (bus.HOLDOFF_CYC == 8'd0) ? 16'd0 : {8'd0, bus.HOLDOFF_CYC} - 16'd1;

    case (state)
      IDLE: begin
        if (bus.TRG_REQ && bus.TRG_MASK != '0) begin
          pending_nxt = bus.TRG_MASK;
          trg_nxt     = bus.TRG_MASK;
          timer_nxt   = '0;
          evt_inc     = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        // TRG keeps the full entry mask even if ACKs arrive during the pulse.
        pending_nxt = pending_clr;
        if (timer == PULSE_LAST) begin
          trg_nxt   = '0;
          timer_nxt = '0;
          state_nxt = WAIT_ACK;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      WAIT_ACK: begin
        pending_nxt = pending_clr;
        timer_nxt   = timer + 16'd1;
        if (pending_clr == '0) begin
          timer_nxt = '0;
          state_nxt = HOLDOFF;
        end else if (bus.TIMEOUT_CYC != 16'd0 && timer == bus.TIMEOUT_CYC - 16'd1) begin
          tmask_nxt = pending_clr;
          tmo_inc   = 1'b1;
          timer_nxt = '0;
          state_nxt = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (timer == hold_last) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && bus.TRG_REQ)
      drop_inc = 1'b1;
  end

  assign bus.TRG          = trg_q;
  assign bus.BUSY         = busy_q;
  assign bus.EVT_CNT      = evt_q;
  assign bus.TIMEOUT_CNT  = tcnt_q;
  assign bus.DROP_CNT     = dcnt_q;
  assign bus.TIMEOUT_MASK = tmask_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_trig_readout_sequencer.sv
// Bench for trig_readout_sequencer: table of single-event vectors plus
// hand sequences for request hold, drop saturation, async reset and wrap.
module tb_trig_readout_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  trig_readout_sequencer_if #(.N_SCROD(12), .EVT_W(32)) bus_if ();

  trig_readout_sequencer #(.N_SCROD(12), .TRG_PULSE_CYC(4), .EVT_W(32)) dut (
    .CLK_42MHZ (clk),
    .RESET     (rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mask;
    int          d0;
    logic [11:0] a0;
    int          d1;
    logic [11:0] a1;
    logic [15:0] tmo;
    logic [7:0]  hold;
    logic        exp_to;
    logic [11:0] exp_tmask;
    int          exp_busy;
    int          exp_wait;
  } vec_t;

  vec_t        vecs[7];
  logic [11:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_evt  = '0;
  logic [15:0] exp_tcnt = '0;
  logic [15:0] exp_drop = '0;
  logic [11:0] exp_tmask_last = '0;
  logic [11:0] trg_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each TRG rising from 0 must match the oldest issued mask.
  always @(negedge clk) begin
    if (bus_if.TRG != '0 && trg_prev == '0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL trg_unexpected: got %0h expected none", bus_if.TRG);
      end else begin
        check("trg_value", {20'd0, bus_if.TRG}, {20'd0, exp_q.pop_front()});
      end
    end
    trg_prev = bus_if.TRG;
  end

  task automatic check_stats(input string tag);
    check({tag, "_evt"},   bus_if.EVT_CNT, exp_evt);
    check({tag, "_tcnt"},  {16'd0, bus_if.TIMEOUT_CNT}, {16'd0, exp_tcnt});
    check({tag, "_drop"},  {16'd0, bus_if.DROP_CNT}, {16'd0, exp_drop});
    check({tag, "_tmask"}, {20'd0, bus_if.TIMEOUT_MASK}, {20'd0, exp_tmask_last});
  endtask

  // One event from idle; ACK pulses are seen at accept edge + d0 / + d1.
  task automatic run_event(input vec_t v, input string tag);
    int  busy_len, trg_len, wait_len;
    logic done;
    @(negedge clk);
    bus_if.TRG_REQ     = 1'b1;
    bus_if.TRG_MASK    = v.mask;
    bus_if.TIMEOUT_CYC = v.tmo;
    bus_if.HOLDOFF_CYC = v.hold;
    exp_q.push_back(v.mask);
    exp_evt = exp_evt + 32'd1;
    @(posedge clk);
    #1 bus_if.TRG_REQ = 1'b0;
    busy_len = 0; trg_len = 0; wait_len = 0; done = 1'b0;
    for (int k = 1; k <= 300 && !done; k++) begin
      bus_if.ACK = (k == v.d0) ? v.a0 : (k == v.d1) ? v.a1 : 12'h000;
      @(negedge clk);
      if (!bus_if.BUSY) done = 1'b1;
      else begin
        busy_len++;
        if (bus_if.TRG != '0) trg_len++;
        if (state_dbg == 2'd2) wait_len++;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    bus_if.ACK = '0;
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_busy_stuck: got busy after 300 cycles expected idle", tag);
    end
    if (v.exp_to) begin
      exp_tcnt       = exp_tcnt + 16'd1;
      exp_tmask_last = v.exp_tmask;
    end
    check({tag, "_busy_len"}, busy_len, v.exp_busy);
    check({tag, "_trg_len"},  trg_len, 4);
    check({tag, "_wait_len"}, wait_len, v.exp_wait);
    check_stats(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          mask     d0  a0       d1  a1       tmo    hold  to    tmask    busy wait
    vecs[0] = '{12'h00F, 10, 12'h00F, 0,  12'h000, 16'd0,  8'd5, 1'b0, 12'h000, 15, 6};
    vecs[1] = '{12'hFFF, 7,  12'h001, 0,  12'h000, 16'd20, 8'd3, 1'b1, 12'hFFE, 27, 20};
    vecs[2] = '{12'h003, 6,  12'h001, 14, 12'h002, 16'd10, 8'd2, 1'b0, 12'h000, 16, 10};
    vecs[3] = '{12'h0F0, 2,  12'h0F0, 0,  12'h000, 16'd50, 8'd0, 1'b0, 12'h000, 6,  1};
    vecs[4] = '{12'h801, 8,  12'hE01, 0,  12'h000, 16'd0,  8'd1, 1'b0, 12'h000, 9,  4};
    vecs[5] = '{12'h801, 5,  12'h001, 0,  12'h000, 16'd3,  8'd4, 1'b1, 12'h800, 11, 3};
    vecs[6] = '{12'h00C, 3,  12'h004, 9,  12'h0F8, 16'd0,  8'd2, 1'b0, 12'h000, 11, 5};

    bus_if.TRG_REQ = 1'b0; bus_if.TRG_MASK = '0; bus_if.TIMEOUT_CYC = '0;
    bus_if.HOLDOFF_CYC = '0; bus_if.ACK = '0; bus_if.EVT_LOAD = 1'b0; bus_if.EVT_LOAD_VAL = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_trg",   {20'd0, bus_if.TRG}, 32'd0);
    check("rst_busy",  {31'd0, bus_if.BUSY}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check_stats("rst");

    for (int i = 0; i < 7; i++) run_event(vecs[i], $sformatf("vec%0d", i));

    // Request held 30 cycles: accept on the first edge, 29 drops, event completes inside.
    @(negedge clk);
    bus_if.TRG_REQ = 1'b1; bus_if.TRG_MASK = 12'h001; bus_if.ACK = 12'h001;
    bus_if.TIMEOUT_CYC = 16'd0; bus_if.HOLDOFF_CYC = 8'd24;
    exp_q.push_back(12'h001);
    exp_evt = exp_evt + 32'd1;
    repeat (30) @(posedge clk);
    #1 bus_if.TRG_REQ = 1'b0; bus_if.ACK = '0;
    exp_drop = exp_drop + 16'd29;
    @(negedge clk);
    check("hold30_busy", {31'd0, bus_if.BUSY}, 32'd0);
    check_stats("hold30");

    // Event with no ACK and no timeout stays in WAIT_ACK; long hold saturates drops.
    @(negedge clk);
    bus_if.TRG_REQ = 1'b1; bus_if.TRG_MASK = 12'h001; bus_if.HOLDOFF_CYC = 8'd1;
    exp_q.push_back(12'h001);
    exp_evt = exp_evt + 32'd1;
    repeat (70000) @(posedge clk);
    #1 bus_if.TRG_REQ = 1'b0;
    exp_drop = 16'hFFFF;
    @(negedge clk);
    check("sat_state", {30'd0, state_dbg}, 32'd2);
    check_stats("sat");

    // Asynchronous reset mid-cycle while waiting for ACK.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_evt = '0; exp_tcnt = '0; exp_drop = '0; exp_tmask_last = '0;
    check("arst_trg",   {20'd0, bus_if.TRG}, 32'd0);
    check("arst_busy",  {31'd0, bus_if.BUSY}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, 32'd0);
    check_stats("arst");
    @(negedge clk);
    rst = 1'b0;
    run_event(vecs[0], "post_rst");

    // Empty mask in IDLE is ignored entirely.
    @(negedge clk);
    bus_if.TRG_REQ = 1'b1; bus_if.TRG_MASK = 12'h000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mask0_trg",  {20'd0, bus_if.TRG}, 32'd0);
      check("mask0_busy", {31'd0, bus_if.BUSY}, 32'd0);
    end
    bus_if.TRG_REQ = 1'b0;
    check_stats("mask0");

    // Preset EVT_CNT to all-ones; the next accepted trigger wraps it to 0.
    @(negedge clk);
    bus_if.EVT_LOAD = 1'b1; bus_if.EVT_LOAD_VAL = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus_if.EVT_LOAD = 1'b0;
    exp_evt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("preset_evt", bus_if.EVT_CNT, exp_evt);
    run_event(vecs[3], "wrap");

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
